// File: rtl/pdm_transmitter.sv
// PDM transmitter: buffers PCM samples in a two-entry FIFO and converts each one
// into OSR bits of a first-order sigma-delta bitstream clocked at clk_i/DIV.
module pdm_transmitter #(
  parameter int W   = 8,
  parameter int DIV = 50,
  parameter int OSR = 128
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic [W-1:0] sample_i,
  input  logic         sample_valid_i,
  output logic         sample_ready_o,
  output logic         pdm_clk_o,
  output logic         pdm_data_o,
  output logic         busy_o,
  output logic         underrun_o
);

  localparam int DCW = $clog2(DIV);
  localparam int BCW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [DCW-1:0] DIV_HALF = DCW'(DIV / 2);
  localparam logic [BCW-1:0] OSR_LAST = BCW'(OSR - 1);
  localparam logic [W-1:0]   MIDSCALE = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_fifo [2];
  logic [1:0]     r_count;
  logic [W-1:0]   r_cur;
  logic [W-1:0]   r_acc;
  logic [DCW-1:0] r_divCnt;
  logic [BCW-1:0] r_bitCnt;
  logic           r_pdmData;
  logic           r_underrun;

  logic           w_push;
  logic           w_pop;
  logic           w_tick;
  logic           w_lastBit;
  logic           w_enterRun;
  logic           w_stayRun;
  logic           w_boundary;
  logic [W:0]     w_sum;

  assign sample_ready_o = (r_count < 2'd2);
  assign w_push         = sample_valid_i & sample_ready_o;
  assign w_tick         = (r_state == S_RUN) && (r_divCnt == DIV_LAST);
  assign w_lastBit      = (r_bitCnt == OSR_LAST);
  assign w_enterRun     = (r_state != S_RUN) && (w_nextState == S_RUN);
  assign w_stayRun      = (r_state == S_RUN) && (w_nextState == S_RUN);
  assign w_boundary     = w_stayRun && w_tick && w_lastBit;
  assign w_pop          = w_enterRun || (w_boundary && (r_count != 2'd0));
  assign w_sum          = {1'b0, r_acc} + {1'b0, r_cur};
  assign pdm_data_o     = r_pdmData;
  assign underrun_o     = r_underrun;

  // Head always sits in entry 0; a pop shifts entry 1 down.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count   <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_fifo[r_count[0]] <= sample_i;
          r_count            <= r_count + 2'd1;
        end
        2'b01: begin
          r_fifo[0] <= r_fifo[1];
          r_count   <= r_count - 2'd1;
        end
        2'b11: begin
          r_fifo[0] <= sample_i;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (!enable_i) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_nextState = (r_count != 2'd0) ? S_RUN : S_WAIT;
        S_WAIT:  w_nextState = (r_count != 2'd0) ? S_RUN : S_WAIT;
        S_RUN:   w_nextState = S_RUN;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o    = 1'b0;
    pdm_clk_o = 1'b0;
    if (r_state == S_RUN) begin
      busy_o    = 1'b1;
      pdm_clk_o = (r_divCnt < DIV_HALF);
    end
  end

  // Accumulator is not cleared at sample boundaries so the error carries over.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cur      <= '0;
      r_acc      <= '0;
      r_divCnt   <= '0;
      r_bitCnt   <= '0;
      r_pdmData  <= 1'b0;
      r_underrun <= 1'b0;
    end else if (w_enterRun) begin
      r_cur     <= r_fifo[0];
      r_acc     <= '0;
      r_divCnt  <= '0;
      r_bitCnt  <= '0;
      r_pdmData <= 1'b0;
    end else if (w_stayRun) begin
      if (w_tick) begin
        r_divCnt  <= '0;
        r_pdmData <= w_sum[W];
        r_acc     <= w_sum[W-1:0];
        if (w_lastBit) begin
          r_bitCnt <= '0;
          if (r_count != 2'd0) begin
            r_cur <= r_fifo[0];
          end else begin
            r_cur      <= MIDSCALE;
            r_underrun <= 1'b1;
          end
        end else begin
          r_bitCnt <= r_bitCnt + BCW'(1);
        end
      end else begin
        r_divCnt <= r_divCnt + DCW'(1);
      end
    end else begin
      r_acc     <= '0;
      r_divCnt  <= '0;
      r_bitCnt  <= '0;
      r_pdmData <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_transmitter.sv
// Directed bench for pdm_transmitter (W=8, DIV=4, OSR=16); expected bits come from a
// sigma-delta reference model queued when samples are pushed.
module tb_pdm_transmitter;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int OSR = 16;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         enable_i = 1'b0;
  logic [W-1:0] sample_i = '0;
  logic         sample_valid_i = 1'b0;
  logic         sample_ready_o;
  logic         pdm_clk_o;
  logic         pdm_data_o;
  logic         busy_o;
  logic         underrun_o;

  int           checks = 0;
  int           errors = 0;
  int           onesCnt = 0;
  logic         expQ[$];
  logic [W-1:0] mAcc = '0;

  pdm_transmitter #(.W(W), .DIV(DIV), .OSR(OSR)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .pdm_clk_o      (pdm_clk_o),
    .pdm_data_o     (pdm_data_o),
    .busy_o         (busy_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] s);
    sample_i       = s;
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
  endtask

  // Reference first-order modulator: one carry bit per accumulation.
  task automatic modelSample(input logic [W-1:0] s, input int nbits);
    logic [W:0] sum;
    for (int i = 0; i < nbits; i++) begin
      sum  = {1'b0, mAcc} + {1'b0, s};
      expQ.push_back(sum[W]);
      mAcc = sum[W-1:0];
    end
  endtask

  task automatic doReset();
    rst_i          = 1'b1;
    enable_i       = 1'b0;
    sample_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    expQ.delete();
    mAcc = '0;
  endtask

  task automatic waitBusy(input string tag, input int limit);
    int n;
    n = 0;
    while (!busy_o && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, busy_o, 1);
  endtask

  // Bit k is valid k*DIV cycles after RUN entry; skip = cycles already spent.
  task automatic runBits(input string tag, input int n, input int skip);
    logic e;
    onesCnt = 0;
    for (int b = 0; b < n; b++) begin
      repeat ((b == 0) ? (DIV - skip) : DIV) tick();
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=queued bit", tag, pdm_data_o);
      end else begin
        e = expQ.pop_front();
        checkOutput(tag, pdm_data_o, e);
      end
      onesCnt += int'(pdm_data_o);
    end
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst ready", sample_ready_o, 1);
    checkOutput("rst busy", busy_o, 0);
    checkOutput("rst pdmclk", pdm_clk_o, 0);
    checkOutput("rst data", pdm_data_o, 0);
    checkOutput("rst underrun", underrun_o, 0);

    // Midscale: alternating bits, clock 2 high / 2 low
    applyStimulus(8'd128);
    modelSample(8'd128, 16);
    enable_i = 1'b1;
    waitBusy("T1 enter", 10);
    checkOutput("T1 clk c0", pdm_clk_o, 1);
    tick();
    checkOutput("T1 clk c1", pdm_clk_o, 1);
    tick();
    checkOutput("T1 clk c2", pdm_clk_o, 0);
    tick();
    checkOutput("T1 clk c3", pdm_clk_o, 0);
    runBits("T1 bits", 16, 3);
    checkOutput("T1 clk c4", pdm_clk_o, 1);
    checkOutput("T1 ones", onesCnt, 8);

    // 64, 0, 255 back-to-back; third push held while FIFO full
    doReset();
    sample_i       = 8'd64;
    sample_valid_i = 1'b1;
    tick();
    checkOutput("T2 ready after 1", sample_ready_o, 1);
    sample_i = 8'd0;
    tick();
    checkOutput("T2 ready after 2", sample_ready_o, 0);
    sample_i = 8'd255;
    tick();
    tick();
    checkOutput("T2 ready held", sample_ready_o, 0);
    checkOutput("T2 idle busy", busy_o, 0);
    modelSample(8'd64, 16);
    modelSample(8'd0, 16);
    modelSample(8'd255, 16);
    enable_i = 1'b1;
    waitBusy("T2 enter", 10);
    checkOutput("T2 ready after pop", sample_ready_o, 1);
    tick();
    sample_valid_i = 1'b0;
    checkOutput("T2 third accepted", sample_ready_o, 0);
    runBits("T2 bits 64", 16, 1);
    checkOutput("T2 ones 64", onesCnt, 4);
    runBits("T2 bits 0", 16, 0);
    checkOutput("T2 ones 0", onesCnt, 0);
    runBits("T2 bits 255", 16, 0);
    checkOutput("T2 ones 255", onesCnt, 15);

    // Underrun after a single sample, midscale fill afterwards
    doReset();
    applyStimulus(8'd128);
    modelSample(8'd128, 20);
    enable_i = 1'b1;
    waitBusy("T3 enter", 10);
    runBits("T3 bits", 15, 0);
    checkOutput("T3 underrun pre", underrun_o, 0);
    runBits("T3 bit16", 1, 0);
    checkOutput("T3 underrun at 16", underrun_o, 1);
    runBits("T3 midscale", 4, 0);
    checkOutput("T3 underrun held", underrun_o, 1);
    enable_i = 1'b0;
    tick();
    checkOutput("T3 idle busy", busy_o, 0);
    checkOutput("T3 idle data", pdm_data_o, 0);
    checkOutput("T3 idle clk", pdm_clk_o, 0);
    checkOutput("T3 underrun sticky", underrun_o, 1);

    // Enable with empty FIFO waits, then a push starts RUN
    doReset();
    enable_i = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("T4 wait busy", busy_o, 0);
    checkOutput("T4 wait clk", pdm_clk_o, 0);
    applyStimulus(8'd200);
    checkOutput("T4 push busy", busy_o, 0);
    tick();
    checkOutput("T4 run busy", busy_o, 1);
    modelSample(8'd200, 4);
    tick();
    tick();
    tick();
    checkOutput("T4 clk c3", pdm_clk_o, 0);
    runBits("T4 bits", 4, 3);

    // Reset mid-RUN clears everything including the FIFO
    doReset();
    applyStimulus(8'd200);
    applyStimulus(8'd64);
    modelSample(8'd200, 3);
    enable_i = 1'b1;
    waitBusy("T5 enter", 10);
    runBits("T5 bits", 3, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    expQ.delete();
    checkOutput("T5 busy", busy_o, 0);
    checkOutput("T5 clk", pdm_clk_o, 0);
    checkOutput("T5 data", pdm_data_o, 0);
    checkOutput("T5 underrun", underrun_o, 0);
    checkOutput("T5 ready", sample_ready_o, 1);
    tick();
    tick();
    tick();
    checkOutput("T5 fifo empty", busy_o, 0);
    enable_i = 1'b0;

    // Dropping enable mid-RUN keeps FIFO contents
    doReset();
    applyStimulus(8'd200);
    applyStimulus(8'd64);
    modelSample(8'd200, 3);
    enable_i = 1'b1;
    waitBusy("T6 enter", 10);
    runBits("T6 bits", 3, 0);
    enable_i = 1'b0;
    tick();
    checkOutput("T6 busy", busy_o, 0);
    checkOutput("T6 data", pdm_data_o, 0);
    checkOutput("T6 clk", pdm_clk_o, 0);
    checkOutput("T6 ready", sample_ready_o, 1);
    applyStimulus(8'd77);
    checkOutput("T6 count kept", sample_ready_o, 0);
    expQ.delete();
    mAcc = '0;
    modelSample(8'd64, 4);
    enable_i = 1'b1;
    waitBusy("T6 resume", 10);
    runBits("T6 resume bits", 4, 0);
    enable_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
